// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen: butterfly address, twiddle address and stage sequencer for a 2^N-point NTT.
// Optional macro NTT_STAGE_BUBBLE_EN inserts BUBBLE idle cycles between consecutive stages.
module ntt_addr_gen #(
    parameter int N      = 3,
    parameter int SW     = 2,
    parameter int BUBBLE = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          inv,
    input  logic          ready,
    output logic          busy,
    output logic          valid,
    output logic [N-1:0]  addr_a,
    output logic [N-1:0]  addr_b,
    output logic [N-1:0]  tf_addr,
    output logic [SW-1:0] stage,
    output logic          tf_down,
    output logic          done
);

    localparam int            JMAXI   = (1 << (N - 1)) - 1;
    localparam logic [N-1:0]  JMAX    = JMAXI[N-1:0];
    localparam int            SLASTI  = N - 1;
    localparam logic [SW-1:0] SLAST   = SLASTI[SW-1:0];
    localparam int            ONEI    = 1;
    localparam logic [N-1:0]  ONE     = ONEI[N-1:0];
    localparam logic [N-1:0]  ALLONES = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] s, s_nxt;
    logic [N-1:0]  j, j_nxt;
    logic          inv_nxt;
    logic [N-1:0]  h, g, o;
    logic [N-1:0]  a_nxt, b_nxt, tf_nxt;
    int            sh;

`ifdef NTT_STAGE_BUBBLE_EN
    localparam int           GW     = (BUBBLE > 1) ? $clog2(BUBBLE) : 1;
    localparam int           GLASTI = BUBBLE - 1;
    localparam logic [GW-1:0] GLAST = GLASTI[GW-1:0];
    logic [GW-1:0] gcnt, gcnt_nxt;
`endif

    assign stage = s;

    // Sequencing: j walks butterflies within a stage, s walks stages.
    always_comb begin
        state_nxt = state;
        s_nxt     = s;
        j_nxt     = j;
        inv_nxt   = tf_down;
`ifdef NTT_STAGE_BUBBLE_EN
        gcnt_nxt  = gcnt;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    inv_nxt   = inv;
                    s_nxt     = '0;
                    j_nxt     = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (ready) begin
                    if (j != JMAX) begin
                        j_nxt = j + 1'b1;
                    end else if (s != SLAST) begin
                        j_nxt = '0;
                        s_nxt = s + 1'b1;
`ifdef NTT_STAGE_BUBBLE_EN
                        gcnt_nxt  = '0;
                        state_nxt = GAP;
`endif
                    end else begin
                        state_nxt = FIN;
                    end
                end
            end
`ifdef NTT_STAGE_BUBBLE_EN
            GAP: begin
                if (gcnt == GLAST) begin
                    state_nxt = RUN;
                end else begin
                    gcnt_nxt = gcnt + 1'b1;
                end
            end
`endif
            FIN: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Descriptor for the upcoming (s, j): half-span h is a power of two, so
    // group/offset split and the group stride reduce to shifts and masks.
    always_comb begin
        sh     = inv_nxt ? int'(s_nxt) : (N - 1 - int'(s_nxt));
        h      = ONE << sh;
        g      = j_nxt >> sh;
        o      = j_nxt & (h - ONE);
        a_nxt  = (g << (sh + 1)) | o;
        b_nxt  = a_nxt + h;
        tf_nxt = inv_nxt ? ((ALLONES >> s_nxt) - g) : ((ONE << s_nxt) + g);
    end

    // All outputs are registered; descriptors are zeroed outside RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            s       <= '0;
            j       <= '0;
            tf_down <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            addr_a  <= '0;
            addr_b  <= '0;
            tf_addr <= '0;
`ifdef NTT_STAGE_BUBBLE_EN
            gcnt    <= '0;
`endif
        end else begin
            state   <= state_nxt;
            s       <= s_nxt;
            j       <= j_nxt;
            tf_down <= inv_nxt;
            valid   <= (state_nxt == RUN);
            busy    <= (state_nxt == RUN) || (state_nxt == GAP);
            done    <= (state_nxt == FIN);
            if (state_nxt == RUN) begin
                addr_a  <= a_nxt;
                addr_b  <= b_nxt;
                tf_addr <= tf_nxt;
            end else begin
                addr_a  <= '0;
                addr_b  <= '0;
                tf_addr <= '0;
            end
`ifdef NTT_STAGE_BUBBLE_EN
            gcnt    <= gcnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_ntt_addr_gen.sv
// tb_ntt_addr_gen: self-checking bench for ntt_addr_gen (N=3) against directed tables
// and an arithmetic reference model of the butterfly schedule.
module tb_ntt_addr_gen;

    localparam int N      = 3;
    localparam int SW     = 2;
    localparam int BUBBLE = 2;
    localparam int HALF   = 1 << (N - 1);
    localparam int BEATS  = N * HALF;
`ifdef NTT_STAGE_BUBBLE_EN
    localparam int GAPLEN = BUBBLE;
`else
    localparam int GAPLEN = 0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, inv, ready;
    logic          busy, valid, tf_down, done;
    logic [N-1:0]  addr_a, addr_b, tf_addr;
    logic [SW-1:0] stage;

    always #5 clk = ~clk;

    ntt_addr_gen #(.N(N), .SW(SW), .BUBBLE(BUBBLE)) dut (
        .clk(clk), .rst(rst), .start(start), .inv(inv), .ready(ready),
        .busy(busy), .valid(valid), .addr_a(addr_a), .addr_b(addr_b),
        .tf_addr(tf_addr), .stage(stage), .tf_down(tf_down), .done(done)
    );

    int compared   = 0;
    int mismatched = 0;

    int oa[$], ob[$], otf[$], ost[$], gaps[$];
    int ocycles, ostalls, hold_bad, tfdown_bad, busy_bad, done_pulses, post_valid;
    int frozen_a, frozen_b, frozen_tf;
    bit timed_out;

    int ea[$], eb[$], etf[$], est[$];

    // Reference schedule straight from the butterfly arithmetic.
    function automatic void build_model(input bit iv);
        int h, g, o, a;
        ea.delete(); eb.delete(); etf.delete(); est.delete();
        for (int s2 = 0; s2 < N; s2++) begin
            for (int jj = 0; jj < HALF; jj++) begin
                h = iv ? (2 ** s2) : (2 ** (N - 1 - s2));
                g = jj / h;
                o = jj % h;
                a = g * 2 * h + o;
                ea.push_back(a);
                eb.push_back(a + h);
                etf.push_back(iv ? (2 ** (N - s2)) - 1 - g : (2 ** s2) + g);
                est.push_back(s2);
            end
        end
    endfunction

    // Runs one transform and records what was observed; judging is left to the tests.
    task automatic applyStimulus(input bit iv, input int stall_at, input int stall_len,
                                 input bit rand_rdy, input int start_at, input bit start_in_fin);
        int cyc, stalled, gap_run, sa, sb, stf, sst;
        bit held, fin_seen, start_fired;
        oa.delete(); ob.delete(); otf.delete(); ost.delete(); gaps.delete();
        ocycles = 0; ostalls = 0; hold_bad = 0; tfdown_bad = 0; busy_bad = 0;
        done_pulses = 0; post_valid = 0; frozen_a = -1; frozen_b = -1; frozen_tf = -1;
        timed_out = 0;
        cyc = 0; stalled = 0; gap_run = 0; held = 0; fin_seen = 0; start_fired = 0;
        sa = 0; sb = 0; stf = 0; sst = 0;
        @(negedge clk);
        start = 1'b1; inv = iv; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!fin_seen && cyc < 1000) begin
            cyc++;
            if (held) begin
                if (valid !== 1'b1 || int'(addr_a) != sa || int'(addr_b) != sb ||
                    int'(tf_addr) != stf || int'(stage) != sst)
                    hold_bad++;
            end
            held = 0;
            if (tf_down !== iv) tfdown_bad++;
            start = 1'b0;
            if (done === 1'b1) begin
                ocycles = cyc;
                done_pulses++;
                fin_seen = 1;
                if (busy !== 1'b0 || valid !== 1'b0) busy_bad++;
                if (start_in_fin) begin
                    start = 1'b1;
                    inv = ~iv;
                end
            end else if (valid === 1'b1) begin
                if (busy !== 1'b1) busy_bad++;
                if (gap_run > 0) begin
                    gaps.push_back(gap_run);
                    gap_run = 0;
                end
                if (start_at >= 0 && oa.size() == start_at && !start_fired) begin
                    start = 1'b1;
                    inv = ~iv;
                    start_fired = 1;
                end
                if (stall_at >= 0 && oa.size() == stall_at && stalled < stall_len) begin
                    ready = 1'b0;
                    if (stalled == 0) begin
                        frozen_a = int'(addr_a); frozen_b = int'(addr_b); frozen_tf = int'(tf_addr);
                    end
                    stalled++;
                end else if (rand_rdy) begin
                    ready = 1'($urandom_range(0, 1));
                end else begin
                    ready = 1'b1;
                end
                if (ready) begin
                    oa.push_back(int'(addr_a)); ob.push_back(int'(addr_b));
                    otf.push_back(int'(tf_addr)); ost.push_back(int'(stage));
                end else begin
                    held = 1;
                    sa = int'(addr_a); sb = int'(addr_b); stf = int'(tf_addr); sst = int'(stage);
                    ostalls++;
                end
            end else begin
                if (busy !== 1'b1) busy_bad++;
                gap_run++;
                ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        if (!fin_seen) timed_out = 1;
        start = 1'b0; ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (done === 1'b1) done_pulses++;
            if (valid !== 1'b0 || busy !== 1'b0) post_valid++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; inv = 1'b0; ready = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_ctrl: got valid=%b busy=%b done=%b want 0 0 0", valid, busy, done);
        end
        compared++;
        if (addr_a !== '0 || addr_b !== '0 || tf_addr !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_addr: got (%0d,%0d,%0d) want (0,0,0)", addr_a, addr_b, tf_addr);
        end
        compared++;
        if (stage !== '0 || tf_down !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_stage: got stage=%0d tf_down=%b want 0 0", stage, tf_down);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_forward();
        int fa[12]  = '{0, 1, 2, 3, 0, 2, 4, 6, 0, 2, 4, 6};
        int fb[12]  = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
        int ftf[12] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7};
        fa[5] = 1; fa[6] = 4; fa[7] = 5;
        applyStimulus(1'b0, -1, 0, 1'b0, -1, 1'b0);
        compared++;
        if (timed_out || oa.size() != BEATS) begin
            mismatched++;
            $display("[TB] FAIL fwd_count: got %0d beats (timeout=%0d) want %0d", oa.size(), timed_out, BEATS);
        end
        for (int i = 0; i < BEATS; i++) begin
            compared++;
            if (i >= oa.size() || oa[i] != fa[i] || ob[i] != fb[i] || otf[i] != ftf[i] || ost[i] != i / HALF) begin
                mismatched++;
                $display("[TB] FAIL fwd_beat%0d: got (%0d,%0d,%0d,s%0d) want (%0d,%0d,%0d,s%0d)", i,
                         (i < oa.size()) ? oa[i] : -1, (i < ob.size()) ? ob[i] : -1,
                         (i < otf.size()) ? otf[i] : -1, (i < ost.size()) ? ost[i] : -1,
                         fa[i], fb[i], ftf[i], i / HALF);
            end
        end
        compared++;
        if (ocycles != BEATS + (N - 1) * GAPLEN + 1 || done_pulses != 1 || post_valid != 0) begin
            mismatched++;
            $display("[TB] FAIL fwd_timing: got cycles=%0d pulses=%0d post=%0d want %0d 1 0",
                     ocycles, done_pulses, post_valid, BEATS + (N - 1) * GAPLEN + 1);
        end
        compared++;
        if (gaps.size() != ((GAPLEN > 0) ? N - 1 : 0)) begin
            mismatched++;
            $display("[TB] FAIL fwd_gaps: got %0d gaps want %0d", gaps.size(), (GAPLEN > 0) ? N - 1 : 0);
        end
        foreach (gaps[k]) begin
            compared++;
            if (gaps[k] != GAPLEN) begin
                mismatched++;
                $display("[TB] FAIL fwd_gaplen%0d: got %0d want %0d", k, gaps[k], GAPLEN);
            end
        end
        compared++;
        if (tfdown_bad != 0 || busy_bad != 0) begin
            mismatched++;
            $display("[TB] FAIL fwd_flags: got tfdown_bad=%0d busy_bad=%0d want 0 0", tfdown_bad, busy_bad);
        end
    endtask

    task automatic test_inverse();
        int ia[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
        int ib[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
        int itf[12] = '{7, 6, 5, 4, 3, 3, 2, 2, 1, 1, 1, 1};
        applyStimulus(1'b1, -1, 0, 1'b0, -1, 1'b0);
        compared++;
        if (timed_out || oa.size() != BEATS) begin
            mismatched++;
            $display("[TB] FAIL inv_count: got %0d beats want %0d", oa.size(), BEATS);
        end
        for (int i = 0; i < BEATS; i++) begin
            compared++;
            if (i >= oa.size() || oa[i] != ia[i] || ob[i] != ib[i] || otf[i] != itf[i] || ost[i] != i / HALF) begin
                mismatched++;
                $display("[TB] FAIL inv_beat%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i,
                         (i < oa.size()) ? oa[i] : -1, (i < ob.size()) ? ob[i] : -1,
                         (i < otf.size()) ? otf[i] : -1, ia[i], ib[i], itf[i]);
            end
        end
        compared++;
        if (tfdown_bad != 0 || busy_bad != 0 || done_pulses != 1) begin
            mismatched++;
            $display("[TB] FAIL inv_flags: got tfdown_bad=%0d busy_bad=%0d pulses=%0d want 0 0 1",
                     tfdown_bad, busy_bad, done_pulses);
        end
    endtask

    task automatic test_backpressure();
        applyStimulus(1'b0, 6, 3, 1'b0, -1, 1'b0);
        build_model(1'b0);
        compared++;
        if (frozen_a != 4 || frozen_b != 6 || frozen_tf != 3) begin
            mismatched++;
            $display("[TB] FAIL bp_frozen: got (%0d,%0d,%0d) want (4,6,3)", frozen_a, frozen_b, frozen_tf);
        end
        compared++;
        if (hold_bad != 0 || ostalls != 3) begin
            mismatched++;
            $display("[TB] FAIL bp_hold: got hold_bad=%0d stalls=%0d want 0 3", hold_bad, ostalls);
        end
        compared++;
        if (oa.size() != BEATS || oa != ea || ob != eb || otf != etf || ost != est) begin
            mismatched++;
            $display("[TB] FAIL bp_sequence: got %0d beats, content differs from model (want %0d)", oa.size(), BEATS);
        end
        compared++;
        if (ocycles != BEATS + 3 + (N - 1) * GAPLEN + 1) begin
            mismatched++;
            $display("[TB] FAIL bp_cycles: got %0d want %0d", ocycles, BEATS + 3 + (N - 1) * GAPLEN + 1);
        end
    endtask

    task automatic test_start_while_busy();
        applyStimulus(1'b0, -1, 0, 1'b0, 5, 1'b1);
        build_model(1'b0);
        compared++;
        if (oa.size() != BEATS || oa != ea || ob != eb || otf != etf || ost != est) begin
            mismatched++;
            $display("[TB] FAIL swb_sequence: got %0d beats, content differs from model (want %0d)", oa.size(), BEATS);
        end
        compared++;
        if (tfdown_bad != 0 || post_valid != 0 || done_pulses != 1) begin
            mismatched++;
            $display("[TB] FAIL swb_ignored: got tfdown_bad=%0d post=%0d pulses=%0d want 0 0 1",
                     tfdown_bad, post_valid, done_pulses);
        end
    endtask

    task automatic test_reset_midrun();
        int beats, cyc;
        bit saw_done;
        beats = 0; cyc = 0; saw_done = 0;
        @(negedge clk);
        start = 1'b1; inv = 1'b0; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (beats < 7 && cyc < 100) begin
            if (valid === 1'b1) beats++;
            if (done === 1'b1) saw_done = 1;
            @(negedge clk);
            cyc++;
        end
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if (beats != 7 || saw_done) begin
            mismatched++;
            $display("[TB] FAIL rstmid_reach: got beats=%0d done_seen=%0d want 7 0", beats, saw_done);
        end
        compared++;
        if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            addr_a !== '0 || addr_b !== '0 || tf_addr !== '0) begin
            mismatched++;
            $display("[TB] FAIL rstmid_clear: got v=%b b=%b d=%b (%0d,%0d,%0d) want 0 0 0 (0,0,0)",
                     valid, busy, done, addr_a, addr_b, tf_addr);
        end
        rst = 1'b0;
        applyStimulus(1'b0, -1, 0, 1'b0, -1, 1'b0);
        build_model(1'b0);
        compared++;
        if (oa.size() != BEATS || oa[0] != 0 || ob[0] != 4 || otf[0] != 1) begin
            mismatched++;
            $display("[TB] FAIL rstmid_first: got %0d beats first=(%0d,%0d,%0d) want %0d (0,4,1)",
                     oa.size(), (oa.size() > 0) ? oa[0] : -1, (ob.size() > 0) ? ob[0] : -1,
                     (otf.size() > 0) ? otf[0] : -1, BEATS);
        end
        compared++;
        if (oa != ea || ob != eb || otf != etf || ost != est) begin
            mismatched++;
            $display("[TB] FAIL rstmid_sequence: got %0d beats, content differs from model", oa.size());
        end
    endtask

    task automatic test_random();
        bit iv;
        for (int it = 0; it < 6; it++) begin
            iv = 1'($urandom_range(0, 1));
            applyStimulus(iv, -1, 0, 1'b1, -1, 1'b0);
            build_model(iv);
            compared++;
            if (timed_out || oa != ea || ob != eb || otf != etf || ost != est) begin
                mismatched++;
                $display("[TB] FAIL rand%0d_sequence: inv=%0d got %0d beats want %0d matching model",
                         it, iv, oa.size(), BEATS);
            end
            compared++;
            if (ocycles != BEATS + ostalls + (N - 1) * GAPLEN + 1) begin
                mismatched++;
                $display("[TB] FAIL rand%0d_cycles: got %0d want %0d", it, ocycles,
                         BEATS + ostalls + (N - 1) * GAPLEN + 1);
            end
            compared++;
            if (hold_bad != 0 || tfdown_bad != 0 || busy_bad != 0 || done_pulses != 1) begin
                mismatched++;
                $display("[TB] FAIL rand%0d_flags: got hold=%0d tfdown=%0d busy=%0d pulses=%0d want 0 0 0 1",
                         it, hold_bad, tfdown_bad, busy_bad, done_pulses);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; inv = 1'b0; ready = 1'b0;
        test_reset();
        test_forward();
        test_inverse();
        test_backpressure();
        test_start_while_busy();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
